// File: rtl/synth_voice_scheduler.sv
// rtl/synth_voice_scheduler.sv - voice allocator with a shadow config published over a 4-phase CDC handshake.
// Optional voice stealing on overflow is enabled by defining VOICE_STEAL_EN.
module synth_voice_scheduler #(
  parameter int N_VOICES = 4,
  parameter int AGE_W    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [23:0]                   cmd_fcw,
  input  logic [4:0]                    cmd_shift,
  output logic [24*N_VOICES-1:0]        carrier_fcws,
  output logic [N_VOICES-1:0]           note_en,
  output logic [23:0]                   mod_fcw,
  output logic [4:0]                    mod_shift,
  output logic                          cdc_req,
  input  logic                          cdc_ack,
  output logic [$clog2(N_VOICES+1)-1:0] active_voices,
  output logic                          overflow
);
  localparam int CNT_W = $clog2(N_VOICES + 1);
  localparam int IW    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [1:0] OP_ON = 2'd0, OP_OFF = 2'd1, OP_MOD = 2'd2, OP_ALL = 2'd3;

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t              state, state_nx;
  logic [23:0]         fcw_q [N_VOICES];
  logic [23:0]         fcw_nx [N_VOICES];
  logic [AGE_W-1:0]    age_q [N_VOICES];
  logic [AGE_W-1:0]    age_nx [N_VOICES];
  logic [N_VOICES-1:0] en_q, en_nx;
  logic [23:0]         mf_q, mf_nx;
  logic [4:0]          ms_q, ms_nx;
  logic                ovf_q, ovf_nx;
  logic                changed;
  logic                hit, free, tgt_valid;
  idx_t                hit_idx, free_idx, tgt_idx;
`ifdef VOICE_STEAL_EN
  idx_t                old_idx;
`endif

  always_comb begin
    fcw_nx    = fcw_q;
    age_nx    = age_q;
    en_nx     = en_q;
    mf_nx     = mf_q;
    ms_nx     = ms_q;
    ovf_nx    = ovf_q;
    changed   = 1'b0;
    state_nx  = state;
    hit       = 1'b0;
    hit_idx   = '0;
    free      = 1'b0;
    free_idx  = '0;
    tgt_valid = 1'b0;
    tgt_idx   = '0;
    // Descending scans leave the lowest matching index behind.
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      if (en_q[i] && fcw_q[i] == cmd_fcw) begin
        hit     = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (!en_q[i]) begin
        free     = 1'b1;
        free_idx = idx_t'(i);
      end
    end
`ifdef VOICE_STEAL_EN
    old_idx = '0;
    for (int i = 1; i < N_VOICES; i++)
      if (age_q[i] > age_q[old_idx]) old_idx = idx_t'(i);
`endif
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_ON: begin
              if (hit) begin
                tgt_valid = 1'b1;
                tgt_idx   = hit_idx;
              end else if (free) begin
                tgt_valid = 1'b1;
                tgt_idx   = free_idx;
                changed   = 1'b1;
              end else begin
                ovf_nx = 1'b1;
`ifdef VOICE_STEAL_EN
                tgt_valid = 1'b1;
                tgt_idx   = old_idx;
                changed   = 1'b1;
`endif
              end
              for (int i = 0; i < N_VOICES; i++)
                if (en_q[i] && !(tgt_valid && idx_t'(i) == tgt_idx) && age_q[i] != '1)
                  age_nx[i] = age_q[i] + AGE_W'(1);
              if (tgt_valid) begin
                age_nx[tgt_idx] = '0;
                fcw_nx[tgt_idx] = cmd_fcw;
                en_nx[tgt_idx]  = 1'b1;
              end
            end
            OP_OFF: begin
              if (hit) begin
                en_nx[hit_idx] = 1'b0;
                changed        = 1'b1;
              end
            end
            OP_MOD: begin
              mf_nx   = cmd_fcw;
              ms_nx   = cmd_shift;
              changed = (cmd_fcw != mf_q) || (cmd_shift != ms_q);
            end
            default: begin
              en_nx   = '0;
              ovf_nx  = 1'b0;
              changed = |en_q;
            end
          endcase
          if (changed) state_nx = S_REQ;
        end
      end
      S_REQ:   if (cdc_ack) state_nx = S_REL;
      S_REL:   if (!cdc_ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      en_q  <= '0;
      mf_q  <= '0;
      ms_q  <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
        fcw_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      state <= state_nx;
      en_q  <= en_nx;
      mf_q  <= mf_nx;
      ms_q  <= ms_nx;
      ovf_q <= ovf_nx;
      for (int i = 0; i < N_VOICES; i++) begin
        fcw_q[i] <= fcw_nx[i];
        age_q[i] <= age_nx[i];
      end
    end
  end

  always_comb begin
    carrier_fcws  = '0;
    active_voices = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      carrier_fcws[24*i +: 24] = fcw_q[i];
      active_voices            = active_voices + CNT_W'(en_q[i]);
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign cdc_req   = (state == S_REQ);
  assign note_en   = en_q;
  assign mod_fcw   = mf_q;
  assign mod_shift = ms_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_synth_voice_scheduler.sv
// tb/tb_synth_voice_scheduler.sv - directed bench with a voice-allocation model checked every cycle.
module tb_synth_voice_scheduler;
  localparam int NV = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = 2'd0;
  logic [23:0]     cmd_fcw = 24'd0;
  logic [4:0]      cmd_shift = 5'd0;
  logic [24*NV-1:0] carrier_fcws;
  logic [NV-1:0]   note_en;
  logic [23:0]     mod_fcw;
  logic [4:0]      mod_shift;
  logic            cdc_req;
  logic            cdc_ack = 1'b0;
  logic [2:0]      active_voices;
  logic            overflow;

  synth_voice_scheduler #(.N_VOICES(NV), .AGE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_fcw(cmd_fcw), .cmd_shift(cmd_shift),
    .carrier_fcws(carrier_fcws), .note_en(note_en), .mod_fcw(mod_fcw),
    .mod_shift(mod_shift), .cdc_req(cdc_req), .cdc_ack(cdc_ack),
    .active_voices(active_voices), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [23:0]   m_fcw [NV];
  int            m_age [NV];
  logic [NV-1:0] m_en;
  logic          m_ovf;
  logic [23:0]   m_mf;
  logic [4:0]    m_ms;
  logic          exp_req;
  logic          exp_ready;

  task automatic cmp(input string nm, input logic [95:0] act, input logic [95:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_fcw[i] = 24'd0;
      m_age[i] = 0;
    end
    m_en = '0; m_ovf = 1'b0; m_mf = 24'd0; m_ms = 5'd0;
    exp_req = 1'b0; exp_ready = 1'b1;
  endtask

  // Applies one accepted command to the model; pub says whether a publish must follow.
  task automatic model_apply(input logic [1:0] op, input logic [23:0] fcw, input logic [4:0] sh,
                             output bit pub);
    int t;
    pub = 1'b0;
    t = -1;
    case (op)
      2'd0: begin
        for (int i = NV - 1; i >= 0; i--) if (m_en[i] && m_fcw[i] == fcw) t = i;
        if (t < 0) begin
          for (int i = NV - 1; i >= 0; i--) if (!m_en[i]) t = i;
          if (t < 0) begin
            m_ovf = 1'b1;
`ifdef VOICE_STEAL_EN
            t = 0;
            for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
`endif
          end
          if (t >= 0) begin
            m_fcw[t] = fcw;
            m_en[t] = 1'b1;
            pub = 1'b1;
          end
        end
        for (int i = 0; i < NV; i++) if (m_en[i] && i != t && m_age[i] < 15) m_age[i]++;
        if (t >= 0) m_age[t] = 0;
      end
      2'd1: begin
        for (int i = NV - 1; i >= 0; i--) if (m_en[i] && m_fcw[i] == fcw) t = i;
        if (t >= 0) begin
          m_en[t] = 1'b0;
          pub = 1'b1;
        end
      end
      2'd2: begin
        pub = (fcw != m_mf) || (sh != m_ms);
        m_mf = fcw;
        m_ms = sh;
      end
      default: begin
        pub = |m_en;
        m_en = '0;
        m_ovf = 1'b0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [24*NV-1:0] ef;
      for (int i = 0; i < NV; i++) ef[24*i +: 24] = m_fcw[i];
      cmp("carrier_fcws", carrier_fcws, ef);
      cmp("note_en", note_en, m_en);
      cmp("active_voices", active_voices, $countones(m_en));
      cmp("overflow", overflow, m_ovf);
      cmp("mod_fcw", mod_fcw, m_mf);
      cmp("mod_shift", mod_shift, m_ms);
      cmp("cdc_req", cdc_req, exp_req);
      cmp("cmd_ready", cmd_ready, exp_ready);
    end
  end

  // Issues one command; while a publish is in flight a junk command is held on the bus.
  task automatic do_cmd(input logic [1:0] op, input logic [23:0] fcw, input logic [4:0] sh,
                        input int ack_dly);
    bit pub;
    cmd_op = op; cmd_fcw = fcw; cmd_shift = sh; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_apply(op, fcw, sh, pub);
    if (pub) begin
      exp_req = 1'b1;
      exp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_fcw = 24'h00BEEF;
      repeat (ack_dly) begin
        @(posedge clk); #1;
      end
      cdc_ack = 1'b1;
      @(posedge clk); #1;
      exp_req = 1'b0;
      cdc_ack = 1'b0;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      exp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit pub;
    model_reset();
    #12;
    cmp("rst_cmd_ready", cmd_ready, 1'b1);
    cmp("rst_cdc_req", cdc_req, 1'b0);
    cmp("rst_note_en", note_en, 4'b0000);
    cmp("rst_overflow", overflow, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    do_cmd(2'd0, 24'h00A000, 5'd0, 3);
    cmp("lit_v0_fcw", carrier_fcws[23:0], 24'h00A000);
    cmp("lit_note_en_1", note_en, 4'b0001);
    cmp("lit_active_1", active_voices, 3'd1);
    do_cmd(2'd3, 24'd0, 5'd0, 1);
    cmp("lit_all_off_en", note_en, 4'b0000);

    do_cmd(2'd0, 24'h001000, 5'd0, 0);
    do_cmd(2'd0, 24'h002000, 5'd0, 2);
    do_cmd(2'd0, 24'h003000, 5'd0, 1);
    do_cmd(2'd0, 24'h004000, 5'd0, 0);
    do_cmd(2'd1, 24'h002000, 5'd0, 1);
    cmp("lit_note_en_1101", note_en, 4'b1101);
    do_cmd(2'd0, 24'h005000, 5'd0, 1);
    cmp("lit_v1_fcw", carrier_fcws[47:24], 24'h005000);
    cmp("lit_note_en_full", note_en, 4'b1111);

    do_cmd(2'd0, 24'h006000, 5'd0, 2);
`ifdef VOICE_STEAL_EN
    cmp("lit_steal_v0", carrier_fcws[23:0], 24'h006000);
`else
    cmp("lit_nosteal_v0", carrier_fcws[23:0], 24'h001000);
`endif
    cmp("lit_ovf_set", overflow, 1'b1);
    cmp("lit_en_after_full", note_en, 4'b1111);

    do_cmd(2'd0, 24'h003000, 5'd0, 1);
    do_cmd(2'd1, 24'h007777, 5'd0, 1);
    do_cmd(2'd2, 24'h123456, 5'd7, 2);
    do_cmd(2'd2, 24'h123456, 5'd7, 1);
    do_cmd(2'd2, 24'h123456, 5'd8, 0);
    do_cmd(2'd3, 24'd0, 5'd0, 3);
    cmp("lit_all_off_ovf", overflow, 1'b0);
    cmp("lit_all_off_en2", note_en, 4'b0000);
    do_cmd(2'd3, 24'd0, 5'd0, 1);

    do_cmd(2'd0, 24'h001000, 5'd0, 1);
    do_cmd(2'd0, 24'h001000, 5'd0, 1);
    cmp("lit_twice_en", note_en, 4'b0001);
    do_cmd(2'd0, 24'h000000, 5'd0, 1);
    cmp("lit_zero_fcw_en", note_en, 4'b0011);

    cdc_ack = 1'b1;
    do_cmd(2'd0, 24'h008000, 5'd0, 0);
    cmp("lit_early_ack_en", note_en, 4'b0111);

    cmd_op = 2'd0; cmd_fcw = 24'h009000; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_apply(2'd0, 24'h009000, 5'd0, pub);
    exp_req = pub;
    exp_ready = ~pub;
    @(posedge clk); #1;
    chk_en = 1'b0;
    cmp("pre_rst_req", cdc_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_cdc_req", cdc_req, 1'b0);
    cmp("arst_note_en", note_en, 4'b0000);
    cmp("arst_carrier", carrier_fcws, 96'd0);
    cmp("arst_overflow", overflow, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmp("post_rst_ready", cmd_ready, 1'b1);
    chk_en = 1'b1;
    do_cmd(2'd0, 24'h00ABCD, 5'd0, 1);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
